window_gen: RTL
===============

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter MAX_W, default 540, maximum image width in pixels.
REQ-003 SHALL have parameter MAX_H, default 360, maximum image height in pixels.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  one-cycle pulse that starts a frame; honoured in IDLE only.
REQ-007 abort_i  input  1  synchronous abort of the current frame.
REQ-008 cfg_w_i  input  10  frame width, sampled on start_i.
REQ-009 cfg_h_i  input  9  frame height, sampled on start_i.
REQ-010 pix_i  input  DATA_W  pixel in raster order.
REQ-011 pix_valid_i  input  1  pix_i valid.
REQ-012 pix_ready_o  output  1  pixel accepted when pix_valid_i and pix_ready_o are both high.
REQ-013 win_o  output  9*DATA_W  3x3 window; slot k=3*i+j at bits [(k+1)*DATA_W-1 : k*DATA_W], row i=0 is top, column j=0 is left.
REQ-014 win_valid_o  output  1  win_o valid.
REQ-015 win_ready_i  input  1  downstream accepts the window.
REQ-016 win_last_o  output  1  marks the final window of the frame; qualified by win_valid_o.
REQ-017 done_o  output  1  one-cycle pulse at frame completion.
REQ-018 cfg_err_o  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-019 FSM states SHALL be IDLE, FILL, RUN and DONE.
REQ-020 IDLE->FILL SHALL occur on start_i when 3<=cfg_w_i<=MAX_W and 3<=cfg_h_i<=MAX_H; W and H are latched at that edge.
REQ-021 Any other start_i in IDLE SHALL pulse cfg_err_o the next cycle and remain in IDLE.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 pix_ready_o SHALL be (state is FILL or RUN) and (!win_valid_o or win_ready_i); the whole pipeline stalls under backpressure.
REQ-024 Column counter c SHALL be 0..W-1, wrapping to 0 and incrementing row r on each accepted pixel at c=W-1.
REQ-025 FILL->RUN SHALL occur on acceptance of pixel (1,W-1).
REQ-026 Two line buffers of MAX_W x DATA_W: on each accept, lb1[c]<=lb0[c] and lb0[c]<=pix_i; the column {lb1[c],lb0[c],pix_i} shifts into a 3-column window register.
REQ-027 Acceptance of pixel (r,c) with r>=2 and c>=2 SHALL present, next cycle, win_valid_o=1 with slot (i,j)=pixel(r-2+i, c-2+j); latency 1 cycle.
REQ-028 Columns c<2 SHALL produce no window and no wrap-across windows.
REQ-029 win_o, win_valid_o and win_last_o SHALL hold stable while win_valid_o=1 and win_ready_i=0.
REQ-030 win_valid_o SHALL clear after a handshake unless a new window loads in the same cycle.
REQ-031 win_last_o=1 SHALL accompany the window for pixel (H-1,W-1); its handshake moves RUN->DONE.
REQ-032 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-033 A frame SHALL emit exactly (W-2)*(H-2) windows.
REQ-034 abort_i in any state SHALL go to IDLE next cycle with win_valid_o=0, counters 0 and no done_o; abort_i has priority over start_i and the handshake.

Reset
REQ-035 Reset SHALL force state IDLE, r=c=0, win_o=0, win_valid_o=0, win_last_o=0, done_o=0 and cfg_err_o=0; pix_ready_o=0 follows from IDLE.
REQ-036 Line-buffer storage SHALL not be reset; stale contents are never emitted, per REQ-027.

Structure
REQ-037 Shared package win_pkg SHALL hold the FSM state enum, localparam K=3 and the default DATA_W, MAX_W and MAX_H.
REQ-038 Line-buffer storage SHALL be sub-module window_gen_lb: single write port and combinational read at column c, RAM-inferable.

Verification
REQ-039 W=4, H=3, pixels 0..11, win_ready_i=1 -> 2 windows: {0,1,2,4,5,6,8,9,10}, then {1,2,3,5,6,7,9,10,11} with win_last_o=1; done_o the next cycle.
REQ-040 Same frame with win_ready_i low for 5 cycles on window 1 -> win_o stable, pix_ready_o=0, no pixel lost, identical output.
REQ-041 start_i with cfg_w_i=2 -> cfg_err_o pulse, state IDLE, pix_ready_o=0.
REQ-042 W=MAX_W, H=MAX_H random pixels vs reference model -> (MAX_W-2)*(MAX_H-2) windows, all match, wrap correct.
REQ-043 abort_i mid-RUN -> IDLE next cycle, win_valid_o=0, no done_o; next 4x3 frame matches REQ-039.
REQ-044 start_i asserted during RUN -> ignored, frame output unchanged.

Source files
------------

// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: FSM states,
// window geometry and the default parameter values.
package win_pkg;

  localparam int K          = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_W  = 540;
  localparam int DEF_MAX_H  = 360;
  localparam int CFG_W_W    = 10;
  localparam int CFG_H_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit offset of window slot (row i, column j) inside the packed window.
  function automatic int slot_lo(input int i, input int j, input int data_w);
    return (K * i + j) * data_w;
  endfunction

endpackage

// File: rtl/window_gen_lb.sv
// Two stacked line buffers held in one RAM: each entry is {lb1, lb0} for a
// column. Single write port, combinational read at the same column.
module window_gen_lb
  import win_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0] lb0_o,
  output logic [DATA_W-1:0] lb1_o
);

  logic [2*DATA_W-1:0] mem [MAX_W];
  logic [2*DATA_W-1:0] rd_word;

  assign rd_word = mem[addr_i];
  assign lb0_o   = rd_word[DATA_W-1:0];
  assign lb1_o   = rd_word[2*DATA_W-1:DATA_W];

  // Storage is deliberately not reset; rows are fully rewritten before use.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[addr_i] <= {rd_word[DATA_W-1:0], pix_i};
    end
  end

endmodule

// File: rtl/window_gen.sv
// Raster-order pixel stream in, 3x3 neighbourhood windows out, with
// valid/ready backpressure that stalls the whole pipeline.
module window_gen
  import win_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int MAX_H  = DEF_MAX_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CFG_W_W-1:0]    cfg_w_i,
  input  logic [CFG_H_W-1:0]    cfg_h_i,
  input  logic [DATA_W-1:0]     pix_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [9*DATA_W-1:0]   win_o,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  win_last_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CFG_W_W-1:0] MAX_W_C = CFG_W_W'(MAX_W);
  localparam logic [CFG_H_W-1:0] MAX_H_C = CFG_H_W'(MAX_H);

  // Handshake rules: a pixel moves when pix_valid_i && pix_ready_o at a
  // rising edge; a window moves when win_valid_o && win_ready_i. Once
  // win_valid_o is high, win_o/win_last_o hold until that handshake.
  state_e               state_q;
  logic [CFG_W_W-1:0]   w_q, c_q;
  logic [CFG_H_W-1:0]   h_q, r_q;
  logic [9*DATA_W-1:0]  win_q, win_d;
  logic                 win_valid_q, win_last_q, done_q, cfg_err_q;

  logic [DATA_W-1:0]    lb0_rd, lb1_rd;
  logic                 accept, hs, cfg_ok, col_end, win_gen, last_pix;

  assign pix_ready_o = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                       (!win_valid_q || win_ready_i);
  assign accept   = pix_valid_i && pix_ready_o;
  assign hs       = win_valid_q && win_ready_i;
  assign cfg_ok   = (cfg_w_i >= CFG_W_W'(3)) && (cfg_w_i <= MAX_W_C) &&
                    (cfg_h_i >= CFG_H_W'(3)) && (cfg_h_i <= MAX_H_C);
  assign col_end  = (c_q == w_q - CFG_W_W'(1));
  assign win_gen  = (r_q >= CFG_H_W'(2)) && (c_q >= CFG_W_W'(2));
  assign last_pix = col_end && (r_q == h_q - CFG_H_W'(1));

  window_gen_lb #(
    .DATA_W (DATA_W),
    .MAX_W  (MAX_W),
    .ADDR_W (AW)
  ) u_lb (
    .clk     (clk),
    .wr_en_i (accept),
    .addr_i  (c_q[AW-1:0]),
    .pix_i   (pix_i),
    .lb0_o   (lb0_rd),
    .lb1_o   (lb1_rd)
  );

  // Shift the window one column left; the new right column is
  // {two rows up, one row up, current pixel} from top to bottom.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_d[slot_lo(i, j, DATA_W) +: DATA_W] = win_q[slot_lo(i, j + 1, DATA_W) +: DATA_W];
      end
    end
    win_d[slot_lo(0, K - 1, DATA_W) +: DATA_W] = lb1_rd;
    win_d[slot_lo(1, K - 1, DATA_W) +: DATA_W] = lb0_rd;
    win_d[slot_lo(2, K - 1, DATA_W) +: DATA_W] = pix_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort_i) begin
        state_q     <= ST_IDLE;
        c_q         <= '0;
        r_q         <= '0;
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              if (cfg_ok) begin
                state_q <= ST_FILL;
                w_q     <= cfg_w_i;
                h_q     <= cfg_h_i;
                c_q     <= '0;
                r_q     <= '0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_FILL, ST_RUN: begin
            if (accept) begin
              win_q       <= win_d;
              win_valid_q <= win_gen;
              win_last_q  <= win_gen && last_pix;
              if (col_end) begin
                c_q <= '0;
                r_q <= r_q + CFG_H_W'(1);
              end else begin
                c_q <= c_q + CFG_W_W'(1);
              end
              if ((state_q == ST_FILL) && col_end && (r_q == CFG_H_W'(1))) begin
                state_q <= ST_RUN;
              end
            end else if (hs) begin
              win_valid_q <= 1'b0;
              win_last_q  <= 1'b0;
            end
            if ((state_q == ST_RUN) && hs && win_last_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            r_q     <= '0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = win_valid_q;
  assign win_last_o  = win_last_q;
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule
